// File: rtl/note_sequencer.sv
// Purpose: queues {period, duration} notes and plays them one at a time as a period value for pwm_gen, with a silent gap after each note.
// Latency: a note pushed in cycle N into an empty, idle, enabled sequencer drives period_out from cycle N+2.
// Backpressure: note_ready drops while the queue is full or flush is asserted; pops are inhibited while enable = 0.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   enable, flush         run/pause control; one-cycle abort of current note and queue
//   note_valid/note_ready producer handshake for note_period (32b) and note_dur (16b, ticks)
//   period_out            registered period to pwm_gen (0 = silent)
//   playing, done         note sounding; one-cycle pulse when the queue has drained after a gap
//   fifo_count            entries currently queued
module note_sequencer #(
  parameter int CLK_PER_TICK = 50000,
  parameter int GAP_TICKS    = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [31:0]                   note_period,
  input  logic [15:0]                   note_dur,
  output logic [31:0]                   period_out,
  output logic                          playing,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(CLK_PER_TICK);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_TICK - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TICKS);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] period;
    logic [15:0] dur;
  } note_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Note queue
  note_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  note_t         head;
  logic          push;
  logic          pop;

  // Sequencer state
  state_t        state, state_d;
  logic [31:0]   period_reg, period_reg_d;
  logic [31:0]   period_out_d;
  logic [PW-1:0] pre, pre_d;
  logic [15:0]   dur_cnt, dur_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          playing_d;
  logic          done_d;
  logic          pre_wrap;

  assign head       = mem[rd_ptr];
  assign note_ready = (fifo_count != FULL) && !flush;
  assign push       = note_valid && note_ready;
  assign pre_wrap   = (pre == PRE_LAST);

  // Storage has no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{period: note_period, dur: note_dur};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      period_reg <= '0;
      period_out <= '0;
      pre        <= '0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      period_reg <= period_reg_d;
      period_out <= period_out_d;
      pre        <= pre_d;
      dur_cnt    <= dur_d;
      gap_cnt    <= gap_d;
      playing    <= playing_d;
      done       <= done_d;
    end
  end

  // period_out and playing are computed for the next cycle so both change on
  // the same edge; any cycle that is not actively playing drives period 0.
  always_comb begin
    state_d      = state;
    period_reg_d = period_reg;
    period_out_d = '0;
    pre_d        = pre;
    dur_d        = dur_cnt;
    gap_d        = gap_cnt;
    playing_d    = 1'b0;
    done_d       = 1'b0;
    pop          = 1'b0;

    if (flush) begin
      state_d      = IDLE;
      period_reg_d = '0;
      pre_d        = '0;
      dur_d        = '0;
      gap_d        = '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && fifo_count != '0) begin
            pop          = 1'b1;
            pre_d        = '0;
            dur_d        = head.dur;
            period_reg_d = head.period;
            // Zero-length notes are consumed without ever sounding.
            if (head.dur != 16'd0) begin
              state_d      = PLAY;
              period_out_d = head.period;
              playing_d    = 1'b1;
            end
          end
        end

        PLAY: begin
          if (enable) begin
            period_out_d = period_reg;
            playing_d    = 1'b1;
            if (pre_wrap) begin
              pre_d = '0;
              // <= 1 rather than == 1 so dur_cnt can never wrap below zero.
              if (dur_cnt <= 16'd1) begin
                dur_d        = '0;
                state_d      = GAP;
                gap_d        = GAP_LOAD;
                period_out_d = '0;
                playing_d    = 1'b0;
              end else begin
                dur_d = dur_cnt - 16'd1;
              end
            end else begin
              pre_d = pre + PW'(1);
            end
          end
        end

        GAP: begin
          if (enable) begin
            // gap_cnt == 0 only when GAP_TICKS is 0: leave after one cycle.
            if (gap_cnt == '0) begin
              state_d = IDLE;
              pre_d   = '0;
              done_d  = (fifo_count == '0) && !push;
            end else if (pre_wrap) begin
              pre_d = '0;
              gap_d = gap_cnt - GW'(1);
              if (gap_cnt == GW'(1)) begin
                state_d = IDLE;
                done_d  = (fifo_count == '0) && !push;
              end
            end else begin
              pre_d = pre + PW'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (GAP_TICKS = 2 and GAP_TICKS = 0) share
// one input stream; a cycle-count reference model predicts every output, and a
// negedge monitor pops the predictions and compares them with both instances.
module tb_note_sequencer;

  localparam int CPT   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] period;
    logic [15:0] dur;
  } note_t;

  typedef struct packed {
    logic [1:0]          rdy;
    logic [1:0]          play;
    logic [1:0]          done;
    logic [1:0][31:0]    per;
    logic [1:0][CW-1:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, flush, note_valid;
  logic [31:0]   note_period;
  logic [15:0]   note_dur;

  logic          rdy_a, play_a, done_a;
  logic [31:0]   per_a;
  logic [CW-1:0] cnt_a;
  logic          rdy_b, play_b, done_b;
  logic [31:0]   per_b;
  logic [CW-1:0] cnt_b;

  note_sequencer #(.CLK_PER_TICK(CPT), .GAP_TICKS(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .note_valid(note_valid), .note_ready(rdy_a),
    .note_period(note_period), .note_dur(note_dur),
    .period_out(per_a), .playing(play_a), .done(done_a), .fifo_count(cnt_a)
  );

  note_sequencer #(.CLK_PER_TICK(CPT), .GAP_TICKS(0), .FIFO_DEPTH(DEPTH)) dut_g0 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .note_valid(note_valid), .note_ready(rdy_b),
    .note_period(note_period), .note_dur(note_dur),
    .period_out(per_b), .playing(play_b), .done(done_b), .fifo_count(cnt_b)
  );

  // Reference model: a note of D ticks is D*CPT enabled cycles of sound, a gap
  // is G*CPT enabled cycles (1 when G = 0); counting is in whole cycles.
  note_t       mq0[$];
  note_t       mq1[$];
  int          m_mode [2];   // 0 idle, 1 sounding, 2 gap
  int          m_rem  [2];
  logic [31:0] m_cur  [2];
  logic [31:0] m_per  [2];
  logic        m_play [2];
  logic        m_done [2];

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mon_cyc = 0;

  logic        rs, ens, fls, vs;
  logic [31:0] ps;
  logic [15:0] ds;

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_clear(input int i);
    if (i == 0) mq0.delete(); else mq1.delete();
    m_mode[i] = 0; m_rem[i] = 0; m_cur[i] = '0;
    m_per[i] = '0; m_play[i] = 1'b0; m_done[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input int gap_ticks);
    logic  rdy_e, push_e;
    note_t n;
    rdy_e  = (qsize(i) != DEPTH) && !flush;
    push_e = note_valid && rdy_e;
    if (reset || flush) begin
      model_clear(i);
    end else begin
      m_per[i] = '0; m_play[i] = 1'b0; m_done[i] = 1'b0;
      if (enable) begin
        if (m_mode[i] == 0) begin
          if (qsize(i) != 0) begin
            if (i == 0) n = mq0.pop_front(); else n = mq1.pop_front();
            if (n.dur != 16'd0) begin
              m_mode[i] = 1;
              m_rem[i]  = int'(n.dur) * CPT;
              m_cur[i]  = n.period;
              m_per[i]  = n.period;
              m_play[i] = 1'b1;
            end
          end
        end else if (m_mode[i] == 1) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_mode[i] = 2;
            m_rem[i]  = (gap_ticks == 0) ? 1 : gap_ticks * CPT;
          end else begin
            m_per[i]  = m_cur[i];
            m_play[i] = 1'b1;
          end
        end else begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_mode[i] = 0;
            m_done[i] = (qsize(i) == 0) && !push_e;
          end
        end
      end
      if (push_e) begin
        if (i == 0) mq0.push_back('{period: note_period, dur: note_dur});
        else        mq1.push_back('{period: note_period, dur: note_dur});
      end
    end
  endtask

  // One clock cycle: drive inputs, queue the outputs expected during this
  // cycle, then advance the model across the closing edge.
  task automatic cyc(input logic r, input logic en, input logic fl, input logic v,
                     input logic [31:0] p, input logic [15:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; enable = en; flush = fl; note_valid = v;
    note_period = p; note_dur = d;
    for (int i = 0; i < 2; i++) begin
      e.rdy[i]  = (qsize(i) != DEPTH) && !fl;
      e.play[i] = m_play[i];
      e.done[i] = m_done[i];
      e.per[i]  = m_per[i];
      e.cnt[i]  = CW'(qsize(i));
    end
    exp_q.push_back(e);
    model_step(0, 2);
    model_step(1, 0);
  endtask

  task automatic idle(input int n, input logic en);
    for (int k = 0; k < n; k++) cyc(1'b0, en, 1'b0, 1'b0, 32'd0, 16'd0);
  endtask

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s[g%0d] cycle %0d: got %0d, expected %0d", nm, (inst == 0) ? 2 : 0, mon_cyc, act, req);
    end
  endtask

  // Monitor: every cycle with a pending prediction is compared at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("note_ready", 0, 32'(rdy_a),  32'(e.rdy[0]));
        chk("period_out", 0, per_a,       e.per[0]);
        chk("playing",    0, 32'(play_a), 32'(e.play[0]));
        chk("done",       0, 32'(done_a), 32'(e.done[0]));
        chk("fifo_count", 0, 32'(cnt_a),  32'(e.cnt[0]));
        chk("note_ready", 1, 32'(rdy_b),  32'(e.rdy[1]));
        chk("period_out", 1, per_b,       e.per[1]);
        chk("playing",    1, 32'(play_b), 32'(e.play[1]));
        chk("done",       1, 32'(done_b), 32'(e.done[1]));
        chk("fifo_count", 1, 32'(cnt_b),  32'(e.cnt[1]));
        mon_cyc++;
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; note_valid = 1'b0;
    note_period = '0; note_dur = '0;
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk);

    // Reset values, held in reset for one more cycle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    idle(2, 1'b1);

    // Single note {100, 3}.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd100, 16'd3);
    idle(26, 1'b1);

    // Five pushes while paused, then play in order.
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'(10 + k), 16'(1 + (k % 2)));
    idle(80, 1'b1);

    // Pause for 7 cycles in the middle of {200, 2}.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd200, 16'd2);
    idle(3, 1'b1);
    idle(7, 1'b0);
    idle(24, 1'b1);

    // Flush while playing with two notes queued; the push offered with it is dropped.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd300, 16'd4);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd301, 16'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd302, 16'd1);
    idle(3, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'd303, 16'd2);
    idle(6, 1'b1);

    // Zero-duration note is dropped.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd50, 16'd0);
    idle(4, 1'b1);

    // Simultaneous push and pop with three queued.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'(21 + k), 16'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd24, 16'd1);
    idle(70, 1'b1);

    // Reset in the middle of the gap, with a push offered during reset.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'd60, 16'd1);
    idle(8, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'd99, 16'd5);
    idle(4, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      rs  = ($urandom_range(0, 199) == 0);
      ens = ($urandom_range(0, 9) != 0);
      fls = ($urandom_range(0, 49) == 0);
      vs  = 1'($urandom_range(0, 1));
      ps  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
      ds  = 16'($urandom_range(0, 3));
      cyc(rs, ens, fls, vs, ps, ds);
    end
    idle(40, 1'b1);

    // Let the monitor consume the last prediction.
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter CLK_PER_TICK, default 50000, clk cycles per duration tick (1 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter GAP_TICKS, default 10, silent ticks inserted after every played note; 0 is legal.
REQ-003 Parameter FIFO_DEPTH, default 4, note queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = sequencer runs, 0 = pause.
REQ-007 flush  input  1  one-cycle request to abort the current note and empty the queue.
REQ-008 note_valid  input  1  producer offers a note.
REQ-009 note_ready  output  1  queue can accept a note.
REQ-010 note_period  input  32  pwm_gen period for the offered note (0 or 1 = rest).
REQ-011 note_dur  input  16  note length in ticks.
REQ-012 period_out  output  32  registered period driven to pwm_gen.period.
REQ-013 playing  output  1  a note is sounding.
REQ-014 done  output  1  one-cycle pulse when the queue has drained.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.

Function
REQ-016 Queue SHALL be a FIFO of {note_period, note_dur}; push when note_valid && note_ready; note_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
REQ-017 Push and pop in the same cycle SHALL leave fifo_count unchanged; push is never taken when full, pop never taken when empty.
REQ-018 FSM states: IDLE, PLAY, GAP.
REQ-019 IDLE: period_out = 0; if enable && fifo_count != 0 && !flush: pop head, load dur_cnt = head dur, period reg = head period, clear prescaler; next state PLAY if dur != 0, else stay IDLE (zero-duration note dropped, period_out stays 0).
REQ-020 Latency: note pushed in cycle N into empty queue while IDLE and enabled -> popped in cycle N+1 -> period_out = note_period from cycle N+2.
REQ-021 PLAY: period_out = loaded period; prescaler counts 0..CLK_PER_TICK-1 and wraps; on each wrap dur_cnt decrements; wrap with dur_cnt == 1 -> period_out = 0, next state GAP, gap_cnt = GAP_TICKS, prescaler cleared.
REQ-022 A note with dur D SHALL drive its period for exactly D*CLK_PER_TICK cycles.
REQ-023 GAP: period_out = 0; prescaler runs; each wrap decrements gap_cnt; GAP lasts GAP_TICKS*CLK_PER_TICK cycles, then IDLE; GAP_TICKS = 0 -> GAP lasts exactly 1 cycle.
REQ-024 Pause: enable = 0 in PLAY or GAP freezes prescaler, dur_cnt, gap_cnt and state; period_out = 0 while paused; on enable = 1 period_out restores next cycle and counting resumes where frozen.
REQ-025 enable = 0 in IDLE SHALL inhibit pops; pushes still accepted.
REQ-026 flush = 1 (any state, any enable): next cycle state = IDLE, fifo_count = 0, period_out = 0, counters cleared, no done pulse; a push offered in the flush cycle is discarded (note_ready forced 0 during flush).
REQ-027 playing = 1 iff state == PLAY && enable; registered-output equivalent (no glitch vs period_out).
REQ-028 done SHALL pulse for 1 cycle on the GAP->IDLE transition when fifo_count == 0 after that cycle's push/pop accounting and no push occurred that cycle.
REQ-029 All counters SHALL be wide enough for parameter maxima; no wrap of dur_cnt below 0.

Reset
REQ-030 While reset = 1 at a clock edge: state = IDLE, FIFO empty (fifo_count = 0), period_out = 0, playing = 0, done = 0, prescaler/dur_cnt/gap_cnt = 0; note_ready = 1 from the first cycle after reset.
REQ-031 reset SHALL take priority over flush, enable and pushes; reset mid-note stops output in the following cycle.

Verification (bench parameters CLK_PER_TICK = 4, GAP_TICKS = 2, FIFO_DEPTH = 4)
REQ-032 Single note: push {period 100, dur 3} at cycle N -> period_out = 100 for cycles N+2..N+13, 0 for 8 GAP cycles, done pulse on the cycle entering IDLE.
REQ-033 Back-pressure: 5 consecutive pushes with enable = 0 -> first 4 accepted, note_ready = 0 and fifo_count = 4 on 5th; enable = 1 -> notes play in push order.
REQ-034 Pause: enable = 0 for 7 cycles mid-PLAY of {200, 2} -> period_out = 0 during pause, total cycles at 200 still 8.
REQ-035 Flush mid-PLAY with 2 queued -> next cycle period_out = 0, fifo_count = 0, state IDLE, no done.
REQ-036 Edge cases: {50, 0} dropped (period_out never 50); GAP_TICKS = 0 build gives 1-cycle gap; simultaneous push/pop at count 3 keeps count 3; reset asserted mid-GAP -> all outputs at reset values next cycle.
